crc8_checker: RTL and testbench
===============================

Name: crc8_checker

Overview:
- Receive-side counterpart of the team's CRC-8 generation model: streaming RTL checker that takes a byte frame whose final byte is the transmitted CRC-8.
- Recomputes the CRC over the payload bytes and compares it with the received CRC byte.
- Reports one result record per frame through a valid/ready handshake.
- Parameterised to cover every catalogue CRC-8 variant (poly/init/xorout/refin/refout). Sits after the byte deserialiser on link/sensor receive paths.

Parameters:
- POLY, 8'h07, generator polynomial, normal (MSB-first) form, x^8 implicit
- INIT, 8'h00, initial CRC register value at frame start
- XOROUT, 8'h00, value XORed onto the final CRC after optional reflection
- REFIN, 1'b0, 1 = bit-reverse each input byte before it enters the CRC
- REFOUT, 1'b0, 1 = bit-reverse the CRC before XOROUT
- LEN_W, 16, width of the payload length counter

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- s_valid  in  1  input byte valid
- s_ready  out  1  checker can accept a byte
- s_data  in  8  frame byte
- s_last  in  1  marks the final byte of the frame, which is the received CRC
- m_valid  out  1  result record valid
- m_ready  in  1  result consumer ready
- m_crc_ok  out  1  1 = computed CRC equals received CRC
- m_crc_calc  out  8  final computed CRC (after REFOUT/XOROUT)
- m_crc_rx  out  8  received CRC byte
- m_len  out  LEN_W  payload byte count, CRC byte excluded

Behaviour:
- Reset: s_ready=1, m_valid=0, m_crc_ok=0, m_crc_calc=0, m_crc_rx=0, m_len=0; internal crc_reg=INIT, len_cnt=0, state ACCEPT.
- States:
  - ACCEPT: s_ready=1. A byte is accepted when s_valid&&s_ready.
  - RESULT: s_ready=0, m_valid=1.
- Accepted byte with s_last=0:
  - d = REFIN ? bitrev(s_data) : s_data.
  - crc_reg <= 8 MSB-first shift steps of (crc_reg ^ d): shift left, XOR POLY when the bit shifted out is 1.
  - len_cnt <= len_cnt+1, saturating at all-ones.
- Accepted byte with s_last=1:
  - The byte is not folded into the CRC.
  - Registered outputs: m_crc_calc = (REFOUT ? bitrev(crc_reg) : crc_reg) ^ XOROUT; m_crc_rx = s_data; m_crc_ok = (m_crc_calc == s_data); m_len = len_cnt.
  - m_valid=1; crc_reg<=INIT; len_cnt<=0; go to RESULT.
- Latency: result visible the cycle after the last byte is accepted.
- RESULT → ACCEPT on m_valid&&m_ready. m_valid drops the next cycle and s_ready rises that same next cycle.
- m_* outputs stay stable while m_valid=1 and m_ready=0.
- Throughput: 1 byte/clk within a frame. Minimum one bubble cycle between frames (the RESULT cycle).
- Frame boundary cases:
  - A single-byte frame (s_last on the first byte) is a zero-length payload: m_len=0, m_crc_calc=(REFOUT?bitrev(INIT):INIT)^XOROUT.
  - s_valid=0 gaps mid-frame are allowed. State holds.
- m_crc_* and m_len hold their last values after the handshake until the next frame result.
- rst mid-frame or in RESULT: partial frame and pending result are discarded, all state returns to reset values, and no record is emitted.

Optional Feature:
- Macro CRC8_CHK_STATS_EN.
- When defined, adds ports:
  - stat_clr  in  1
  - stat_good  out  16
  - stat_bad  out  16
- stat_good/stat_bad increment on each result handshake (m_valid&&m_ready) according to m_crc_ok. Both saturate at 16'hFFFF and reset to 0.
- stat_clr=1 zeroes both the next cycle. Clear wins over a coincident increment.
- When not defined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- SMBus defaults: bytes "123456789" (31..39 hex) then F4 with s_last, m_ready=1 → m_valid one cycle after, m_crc_ok=1, m_crc_calc=F4, m_len=9.
- AUTOSAR (POLY=2F, INIT=FF, XOROUT=FF): "123456789" + DF → ok=1. Same payload + DE → ok=0, m_crc_calc=DF, m_crc_rx=DE.
- Reflected variants:
  - MAXIM-DOW (POLY=31, REFIN=REFOUT=1): "123456789" + A1 → ok=1.
  - ROHC (POLY=07, INIT=FF, refl): "123456789" + D0 → ok=1.
- Backpressure and stalls:
  - Hold m_ready=0 for 5 cycles after a result → s_ready=0, m_* stable, no bytes accepted.
  - Random s_valid gaps mid-frame → same result as the gapless run.
- Zero-length frame with SMBus defaults: single byte 00 with s_last → ok=1, m_len=0. Single byte 01 → ok=0.
- Reset cases:
  - rst asserted after 4 payload bytes, then a full valid frame → exactly one result, ok=1, m_len=9.
  - With CRC8_CHK_STATS_EN: 3 good + 2 bad frames → stat_good=3, stat_bad=2. stat_clr asserted coincident with a handshake → both counters 0.

Source files
------------

// File: rtl/crc8_checker.sv
// Streaming CRC-8 frame checker: folds payload bytes, compares against the trailing CRC byte.
// Optional result statistics counters enabled by defining CRC8_CHK_STATS_EN.
module crc8_checker #(
   parameter logic [7:0]  POLY   = 8'h07,
   parameter logic [7:0]  INIT   = 8'h00,
   parameter logic [7:0]  XOROUT = 8'h00,
   parameter logic        REFIN  = 1'b0,
   parameter logic        REFOUT = 1'b0,
   parameter int unsigned LEN_W  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [7:0]       s_data,
   input  logic             s_last,
   output logic             m_valid,
   input  logic             m_ready,
   output logic             m_crc_ok,
   output logic [7:0]       m_crc_calc,
   output logic [7:0]       m_crc_rx,
   output logic [LEN_W-1:0] m_len
`ifdef CRC8_CHK_STATS_EN
   ,
   input  logic             stat_clr,
   output logic [15:0]      stat_good,
   output logic [15:0]      stat_bad
`endif
);

   localparam logic [0:0] ACCEPT = 1'b0;
   localparam logic [0:0] RESULT = 1'b1;

   logic [0:0]       state;
   logic [0:0]       state_nx;
   logic [7:0]       crc_reg;
   logic [LEN_W-1:0] len_cnt;
   logic [7:0]       crc_fold;
   logic [7:0]       crc_fin;
   logic             accept;
   logic             handshake;

   function automatic logic [7:0] bitrev(input logic [7:0] v);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = v[7-i];
      return r;
   endfunction

   // One byte of MSB-first CRC update.
   function automatic logic [7:0] crc_step(input logic [7:0] c, input logic [7:0] d);
      logic [7:0] r;
      r = c ^ d;
      for (int i = 0; i < 8; i++) r = r[7] ? ({r[6:0], 1'b0} ^ POLY) : {r[6:0], 1'b0};
      return r;
   endfunction

   assign accept    = s_valid && s_ready;
   assign handshake = m_valid && m_ready;

   always_comb begin
      state_nx = state;
      crc_fold = crc_step(crc_reg, REFIN ? bitrev(s_data) : s_data);
      crc_fin  = (REFOUT ? bitrev(crc_reg) : crc_reg) ^ XOROUT;
      case (state)
         ACCEPT:  if (accept && s_last) state_nx = RESULT;
         RESULT:  if (handshake) state_nx = ACCEPT;
         default: state_nx = ACCEPT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ACCEPT;
         s_ready    <= 1'b1;
         m_valid    <= 1'b0;
         m_crc_ok   <= 1'b0;
         m_crc_calc <= 8'h00;
         m_crc_rx   <= 8'h00;
         m_len      <= '0;
         crc_reg    <= INIT;
         len_cnt    <= '0;
      end else begin
         state   <= state_nx;
         s_ready <= (state_nx == ACCEPT);
         m_valid <= (state_nx == RESULT);
         if (accept) begin
            if (!s_last) begin
               crc_reg <= crc_fold;
               if (len_cnt != {LEN_W{1'b1}}) len_cnt <= len_cnt + LEN_W'(1);
            end else begin
               // The CRC byte itself is compared, never folded.
               m_crc_calc <= crc_fin;
               m_crc_rx   <= s_data;
               m_crc_ok   <= (crc_fin == s_data);
               m_len      <= len_cnt;
               crc_reg    <= INIT;
               len_cnt    <= '0;
            end
         end
      end
   end

`ifdef CRC8_CHK_STATS_EN
   // Clear takes priority over an increment in the same cycle.
   always_ff @(posedge clk) begin
      if (rst || stat_clr) begin
         stat_good <= 16'h0000;
         stat_bad  <= 16'h0000;
      end else if (handshake) begin
         if (m_crc_ok && stat_good != 16'hFFFF) stat_good <= stat_good + 16'd1;
         if (!m_crc_ok && stat_bad != 16'hFFFF) stat_bad <= stat_bad + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_crc8_checker.sv
// Directed bench for crc8_checker: four catalogue variants (SMBus, AUTOSAR, MAXIM-DOW, ROHC)
// share one input stream; each result is compared with hand-computed catalogue check values.
module tb_crc8_checker;

   localparam logic [31:0] POLYS = {8'h07, 8'h31, 8'h2F, 8'h07};
   localparam logic [31:0] INITS = {8'hFF, 8'h00, 8'hFF, 8'h00};
   localparam logic [31:0] XORS  = {8'h00, 8'h00, 8'hFF, 8'h00};
   localparam logic [3:0]  REFS  = 4'b1100;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        s_valid = 1'b0;
   logic [7:0]  s_data = 8'h00;
   logic        s_last = 1'b0;
   logic        m_ready = 1'b1;
   logic [3:0]  srdy, mval, mok;
   logic [7:0]  calc [4];
   logic [7:0]  rx [4];
   logic [15:0] len [4];
`ifdef CRC8_CHK_STATS_EN
   logic        stat_clr = 1'b0;
   logic [15:0] sgood [4];
   logic [15:0] sbad [4];
`endif

   int checks = 0;
   int errors = 0;
   int hs_cnt = 0;
   logic [7:0] pay [9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
   logic [7:0] chk [4] = '{8'hF4, 8'hDF, 8'hA1, 8'hD0};

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      crc8_checker #(
         .POLY(POLYS[g*8 +: 8]), .INIT(INITS[g*8 +: 8]), .XOROUT(XORS[g*8 +: 8]),
         .REFIN(REFS[g]), .REFOUT(REFS[g]), .LEN_W(16)
      ) u_dut (
         .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(srdy[g]), .s_data(s_data),
         .s_last(s_last), .m_valid(mval[g]), .m_ready(m_ready), .m_crc_ok(mok[g]),
         .m_crc_calc(calc[g]), .m_crc_rx(rx[g]), .m_len(len[g])
`ifdef CRC8_CHK_STATS_EN
         , .stat_clr(stat_clr), .stat_good(sgood[g]), .stat_bad(sbad[g])
`endif
      );
   end

   always @(posedge clk) if (mval[0] && m_ready) hs_cnt <= hs_cnt + 1;

   // Drives n payload bytes then the CRC byte; returns at the negedge where the result is visible.
   task automatic drive_frame(input int n, input logic [7:0] crc, input bit gaps);
      for (int i = 0; i < n; i++) begin
         if (gaps && (i % 3 == 1)) begin
            s_valid = 1'b0;
            @(negedge clk);
            @(negedge clk);
         end
         s_valid = 1'b1; s_data = pay[i]; s_last = 1'b0;
         @(negedge clk);
      end
      s_valid = 1'b1; s_data = crc; s_last = 1'b1;
      @(negedge clk);
      s_valid = 1'b0; s_last = 1'b0;
   endtask

   // With m_ready high the record is consumed on the next edge; step over the bubble.
   task automatic finish_result(input string name);
      @(negedge clk);
      checks++;
      if (mval !== 4'h0 || srdy !== 4'hF) begin
         errors++;
         $display("FAIL %s_release m_valid=%b s_ready=%b expected 0000/1111", name, mval, srdy);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      checks++;
      if (srdy !== 4'hF || mval !== 4'h0 || mok !== 4'h0 || calc[0] !== 8'h00 ||
          rx[0] !== 8'h00 || len[0] !== 16'h0) begin
         errors++;
         $display("FAIL reset_state s_ready=%b m_valid=%b ok=%b calc=%h rx=%h len=%0d", srdy, mval,
                  mok, calc[0], rx[0], len[0]);
      end
   endtask

   task automatic test_variants();
      for (int k = 0; k < 4; k++) begin
         drive_frame(9, chk[k], 1'b0);
         checks++;
         if (mval !== 4'hF || srdy !== 4'h0) begin
            errors++;
            $display("FAIL variant%0d_latency m_valid=%b s_ready=%b expected 1111/0000", k, mval, srdy);
         end
         checks++;
         if (mok !== 4'(1 << k)) begin
            errors++;
            $display("FAIL variant%0d_ok got %b expected %b", k, mok, 4'(1 << k));
         end
         for (int j = 0; j < 4; j++) begin
            checks++;
            if (calc[j] !== chk[j] || rx[j] !== chk[k] || len[j] !== 16'd9) begin
               errors++;
               $display("FAIL variant%0d_dut%0d calc=%h rx=%h len=%0d expected %h/%h/9", k, j,
                        calc[j], rx[j], len[j], chk[j], chk[k]);
            end
         end
         finish_result("variant");
      end
   endtask

   task automatic test_autosar_bad();
      drive_frame(9, 8'hDE, 1'b0);
      checks++;
      if (mok[1] !== 1'b0 || calc[1] !== 8'hDF || rx[1] !== 8'hDE) begin
         errors++;
         $display("FAIL autosar_bad ok=%b calc=%h rx=%h expected 0/DF/DE", mok[1], calc[1], rx[1]);
      end
      finish_result("autosar_bad");
   endtask

   task automatic test_backpressure();
      m_ready = 1'b0;
      drive_frame(9, 8'hF4, 1'b0);
      s_valid = 1'b1; s_data = 8'hAA; s_last = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checks++;
         if (mval !== 4'hF || srdy !== 4'h0 || mok !== 4'b0001 || calc[0] !== 8'hF4 ||
             len[0] !== 16'd9) begin
            errors++;
            $display("FAIL stall_cycle%0d m_valid=%b s_ready=%b ok=%b calc=%h len=%0d", c, mval,
                     srdy, mok, calc[0], len[0]);
         end
      end
      s_valid = 1'b0;
      m_ready = 1'b1;
      finish_result("stall");
      checks++;
      if (calc[0] !== 8'hF4 || len[0] !== 16'd9) begin
         errors++;
         $display("FAIL hold_after_hs calc=%h len=%0d expected F4/9", calc[0], len[0]);
      end
      // Any junk byte absorbed during the stall would corrupt this frame.
      drive_frame(9, 8'hF4, 1'b0);
      checks++;
      if (mok[0] !== 1'b1 || len[0] !== 16'd9) begin
         errors++;
         $display("FAIL post_stall_frame ok=%b len=%0d expected 1/9", mok[0], len[0]);
      end
      finish_result("post_stall");
   endtask

   task automatic test_gaps();
      drive_frame(9, 8'hF4, 1'b1);
      checks++;
      if (mok !== 4'b0001 || calc[0] !== 8'hF4 || calc[3] !== 8'hD0 || len[0] !== 16'd9) begin
         errors++;
         $display("FAIL gaps ok=%b calc0=%h calc3=%h len=%0d expected 0001/F4/D0/9", mok, calc[0],
                  calc[3], len[0]);
      end
      finish_result("gaps");
   endtask

   task automatic test_zero_length();
      drive_frame(0, 8'h00, 1'b0);
      checks++;
      if (mok !== 4'b0111 || calc[0] !== 8'h00 || calc[3] !== 8'hFF || len[0] !== 16'd0) begin
         errors++;
         $display("FAIL zero_len_00 ok=%b calc0=%h calc3=%h len=%0d expected 0111/00/FF/0", mok,
                  calc[0], calc[3], len[0]);
      end
      finish_result("zero_len");
      drive_frame(0, 8'h01, 1'b0);
      checks++;
      if (mok !== 4'b0000 || rx[0] !== 8'h01 || len[0] !== 16'd0) begin
         errors++;
         $display("FAIL zero_len_01 ok=%b rx=%h len=%0d expected 0000/01/0", mok, rx[0], len[0]);
      end
      finish_result("zero_len");
   endtask

   task automatic test_mid_frame_reset();
      int hs0;
      drive_frame(0, 8'hF4, 1'b0);
      finish_result("pre_reset");
      for (int i = 0; i < 4; i++) begin
         s_valid = 1'b1; s_data = pay[i]; s_last = 1'b0;
         @(negedge clk);
      end
      s_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (mval !== 4'h0 || srdy !== 4'hF || calc[0] !== 8'h00 || len[0] !== 16'd0) begin
         errors++;
         $display("FAIL mid_reset m_valid=%b s_ready=%b calc=%h len=%0d expected 0/F/00/0", mval,
                  srdy, calc[0], len[0]);
      end
      hs0 = hs_cnt;
      drive_frame(9, 8'hF4, 1'b0);
      checks++;
      if (mok[0] !== 1'b1 || len[0] !== 16'd9) begin
         errors++;
         $display("FAIL reset_then_frame ok=%b len=%0d expected 1/9", mok[0], len[0]);
      end
      finish_result("reset_frame");
      repeat (3) @(negedge clk);
      checks++;
      if (hs_cnt - hs0 !== 1) begin
         errors++;
         $display("FAIL reset_result_count got %0d expected 1", hs_cnt - hs0);
      end
   endtask

`ifdef CRC8_CHK_STATS_EN
   task automatic test_stats();
      stat_clr = 1'b1;
      @(negedge clk);
      stat_clr = 1'b0;
      for (int f = 0; f < 5; f++) begin
         drive_frame(9, (f < 3) ? 8'hF4 : 8'h00, 1'b0);
         finish_result("stats");
      end
      checks++;
      if (sgood[0] !== 16'd3 || sbad[0] !== 16'd2) begin
         errors++;
         $display("FAIL stats_count good=%0d bad=%0d expected 3/2", sgood[0], sbad[0]);
      end
      drive_frame(9, 8'hF4, 1'b0);
      stat_clr = 1'b1;
      @(negedge clk);
      stat_clr = 1'b0;
      checks++;
      if (sgood[0] !== 16'd0 || sbad[0] !== 16'd0) begin
         errors++;
         $display("FAIL stats_clear good=%0d bad=%0d expected 0/0", sgood[0], sbad[0]);
      end
   endtask
`endif

   initial begin
      @(negedge clk);
      test_reset();
      test_variants();
      test_autosar_bad();
      test_backpressure();
      test_gaps();
      test_zero_length();
      test_mid_frame_reset();
`ifdef CRC8_CHK_STATS_EN
      test_stats();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
